// File: rtl/compair_axis_pkg.sv
// rtl/compair_axis_pkg.sv - shared types and helpers for the AXIS round-robin packet arbiter
package compair_axis_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin requester search starting at ptr
module rr_pick #(
    parameter int N_PORTS = 4,
    localparam int IW = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    int cand;

    // Walk offsets from the far end so the nearest requester to ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            if (req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - N-input round-robin AXIS packet arbiter feeding the FIFO write port
module axis_rr_packet_arbiter
    import compair_axis_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int DWIDTH    = 8,
    parameter int TID_WIDTH = 4,
    parameter int TLAST     = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS*DWIDTH-1:0]    s_axis_tdata,
    input  logic [N_PORTS-1:0]           s_axis_tvalid,
    input  logic [N_PORTS-1:0]           s_axis_tlast,
    output logic [N_PORTS-1:0]           s_axis_tready,
    output logic [DWIDTH-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [TID_WIDTH-1:0]         m_axis_tid,
    output logic                         grant_active,
    output logic [$clog2(N_PORTS)-1:0]   grant_idx
);

    localparam int IW = $clog2(N_PORTS);
    localparam logic [7:0] BURST_LAST = (MAX_BURST == 0) ? 8'd0 : 8'(MAX_BURST - 1);

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gidx_q;
    logic [7:0]    beat_cnt;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          in_grant;
    logic          burst_end;
    logic          accept;
    logic          release_beat;

    rr_pick #(.N_PORTS(N_PORTS)) u_rr_pick (
        .req   (s_axis_tvalid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_grant     = (state == ARB_GRANT);
    assign grant_active = in_grant;
    assign grant_idx    = gidx_q;
    assign m_axis_tid   = TID_WIDTH'(gidx_q);

    assign m_axis_tdata  = s_axis_tdata[gidx_q*DWIDTH +: DWIDTH];
    assign m_axis_tvalid = in_grant && s_axis_tvalid[gidx_q];
    assign burst_end     = (MAX_BURST != 0) && (beat_cnt == BURST_LAST);
    // Output tlast doubles as the release condition: real tlast or forced frame end at burst limit.
    assign m_axis_tlast  = in_grant && (((TLAST != 0) && s_axis_tlast[gidx_q]) || burst_end);
    assign accept        = m_axis_tvalid && m_axis_tready;
    assign release_beat  = accept && m_axis_tlast;

    always_comb begin
        s_axis_tready = '0;
        if (in_grant) begin
            s_axis_tready[gidx_q] = m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            gidx_q   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gidx_q   <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (release_beat) begin
                        beat_cnt <= '0;
                        rr_ptr   <= IW'(rr_next(int'(gidx_q), N_PORTS));
                        state    <= ARB_IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb/tb_axis_rr_packet_arbiter.sv - directed vector bench for the round-robin packet arbiter
module tb_axis_rr_packet_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tid;
    logic        grant_active;
    logic [1:0]  grant_idx;

    int checks;
    int failures;

    axis_rr_packet_arbiter #(
        .N_PORTS(4), .DWIDTH(8), .TID_WIDTH(4), .TLAST(1), .MAX_BURST(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .grant_active  (grant_active),
        .grant_idx     (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       mrdy;
        logic [3:0] rdy;
        logic       mvld;
        logic       mlast;
        logic       ga;
        logic [1:0] gidx;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic mrdy);
        @(negedge clk);
        s_axis_tvalid = vld;
        s_axis_tlast  = lst;
        m_axis_tready = mrdy;
        #1;
    endtask

    int beats;
    int idles;

    initial begin
        checks = 0;
        failures = 0;
        s_axis_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        rst = 1'b1;

        //           vld    lst    mrdy   rdy    mvld  mlast ga    gidx
        vecs[0]  = '{4'hf, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{4'hf, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{4'hf, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0};
        vecs[3]  = '{4'hf, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{4'hf, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[5]  = '{4'hf, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 2'd1};
        vecs[6]  = '{4'hf, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[7]  = '{4'hf, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[8]  = '{4'hf, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 2'd2};
        vecs[9]  = '{4'hf, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[10] = '{4'hf, 4'h0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 2'd3};
        vecs[11] = '{4'hf, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 2'd3};
        vecs[12] = '{4'h9, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd3};
        vecs[13] = '{4'h9, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0};
        vecs[14] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_tready", 32'(s_axis_tready), 32'h0);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_ga", 32'(grant_active), 32'h0);
        chk("rst_gidx", 32'(grant_idx), 32'h0);
        rst = 1'b0;

        // round robin across all ports, then wrap from port 3 to port 0
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].vld, vecs[i].lst, vecs[i].mrdy);
            chk($sformatf("v%0d_tready", i), 32'(s_axis_tready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].mvld));
            chk($sformatf("v%0d_mlast", i), 32'(m_axis_tlast), 32'(vecs[i].mlast));
            chk($sformatf("v%0d_ga", i), 32'(grant_active), 32'(vecs[i].ga));
            chk($sformatf("v%0d_gidx", i), 32'(grant_idx), 32'(vecs[i].gidx));
            chk($sformatf("v%0d_tid", i), 32'(m_axis_tid), 32'(vecs[i].gidx));
            if (vecs[i].mvld) begin
                chk($sformatf("v%0d_tdata", i), 32'(m_axis_tdata), 32'(8'hA0 + 8'(vecs[i].gidx)));
            end
        end

        // 40-beat packet on port 2 split by burst limit at beats 16 and 32
        beats = 0;
        idles = 0;
        for (int cyc = 0; cyc < 200 && beats < 40; cyc++) begin
            drive(4'h4, (beats == 39) ? 4'h4 : 4'h0, 1'b1);
            if (!grant_active) begin
                idles++;
            end else if (m_axis_tvalid) begin
                beats++;
                chk($sformatf("burst_b%0d_tlast", beats), 32'(m_axis_tlast),
                    32'(beats == 16 || beats == 32 || beats == 40));
                chk($sformatf("burst_b%0d_tid", beats), 32'(m_axis_tid), 32'd2);
            end
        end
        chk("burst_beats", 32'(beats), 32'd40);
        chk("burst_idles", 32'(idles), 32'd3);

        // port 1 stalls mid-packet while port 3 waits
        drive(4'h2, 4'h0, 1'b1);
        chk("stall_idle_ga", 32'(grant_active), 32'h0);
        drive(4'ha, 4'h0, 1'b1);
        chk("stall_g1_gidx", 32'(grant_idx), 32'd1);
        chk("stall_g1_mvalid", 32'(m_axis_tvalid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(4'h8, 4'h0, 1'b1);
            chk($sformatf("stall_%0d_mvalid", k), 32'(m_axis_tvalid), 32'd0);
            chk($sformatf("stall_%0d_tready", k), 32'(s_axis_tready), 32'h2);
            chk($sformatf("stall_%0d_gidx", k), 32'(grant_idx), 32'd1);
        end
        drive(4'ha, 4'h2, 1'b1);
        chk("stall_end_mvalid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_end_mlast", 32'(m_axis_tlast), 32'd1);
        chk("stall_end_gidx", 32'(grant_idx), 32'd1);
        drive(4'h8, 4'h0, 1'b1);
        chk("stall_rel_ga", 32'(grant_active), 32'd0);
        drive(4'h8, 4'h8, 1'b1);
        chk("stall_p3_gidx", 32'(grant_idx), 32'd3);
        chk("stall_p3_tready", 32'(s_axis_tready), 32'h8);

        // downstream full for 10 cycles: no progress on the burst counter
        drive(4'h1, 4'h0, 1'b1);
        chk("full_idle_ga", 32'(grant_active), 32'd0);
        drive(4'h1, 4'h0, 1'b1);
        chk("full_b1_gidx", 32'(grant_idx), 32'd0);
        chk("full_b1_mvalid", 32'(m_axis_tvalid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(4'h1, 4'h0, 1'b0);
            chk($sformatf("full_%0d_tready", k), 32'(s_axis_tready), 32'h0);
            chk($sformatf("full_%0d_mvalid", k), 32'(m_axis_tvalid), 32'd1);
            chk($sformatf("full_%0d_tdata", k), 32'(m_axis_tdata), 32'hA0);
            chk($sformatf("full_%0d_tid", k), 32'(m_axis_tid), 32'd0);
            chk($sformatf("full_%0d_ga", k), 32'(grant_active), 32'd1);
        end
        for (int k = 1; k <= 15; k++) begin
            drive(4'h1, 4'h0, 1'b1);
            chk($sformatf("full_resume_%0d_mlast", k), 32'(m_axis_tlast), 32'(k == 15));
        end

        // reset in the middle of a port 2 packet
        drive(4'h5, 4'h0, 1'b1);
        chk("mrst_idle_ga", 32'(grant_active), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(4'h5, 4'h0, 1'b1);
            chk($sformatf("mrst_b%0d_gidx", k), 32'(grant_idx), 32'd2);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_tready", 32'(s_axis_tready), 32'h0);
        chk("mrst_ga", 32'(grant_active), 32'd0);
        chk("mrst_gidx", 32'(grant_idx), 32'd0);
        chk("mrst_mvalid", 32'(m_axis_tvalid), 32'd0);
        drive(4'h5, 4'h0, 1'b1);
        chk("mrst_regrant_ga", 32'(grant_active), 32'd1);
        chk("mrst_regrant_gidx", 32'(grant_idx), 32'd0);
        chk("mrst_regrant_tready", 32'(s_axis_tready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
